// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues reads to instruction memory,
// buffers {pc, inst} in a prefetch FIFO and hands them to decode.
// Ports:
//   clk, reset (async, active-high)
//   imem_rd/imem_addr -> memory, imem_data <- memory (one cycle later)
//   redirect_valid/redirect_pc : flush and restart fetch at a new PC
//   inst_valid/inst/inst_pc -> decode, inst_ready <- decode
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;

  logic [INST_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic [CW-1:0]     occupancy;
  logic              push;
  logic              pop;

  // Reserve a slot for the in-flight return; same-cycle pops are
  // ignored, so a returning word always has room.
  assign occupancy = count + CW'(inflight);
  assign imem_rd   = !redirect_valid && (occupancy < CW'(DEPTH));
  assign imem_addr = fetch_pc;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;

  assign push = inflight && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      q_inst[wr_ptr] <= imem_data;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a one-cycle
// instruction memory model holding inst[k] = k[15:0].
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int reqs;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // Garbage when idle so a spurious push is visible.
  always @(posedge clk)
    imem_data <= imem_rd ? imem_addr[15:0] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_v"},  32'(inst_valid), 32'd1);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_i"},  32'(inst), {16'h0, pc[15:0]});
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    nxt();
    nxt();
    chk("rst_v",  32'(inst_valid), 32'd0);
    chk("rst_i",  32'(inst), 32'd0);
    chk("rst_pc", inst_pc, 32'd0);

    // Streaming with ready=1
    reset      = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("t1_rd",   32'(imem_rd), 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    nxt();
    chk("t1_lat_v", 32'(inst_valid), 32'd0);
    nxt();
    for (int i = 0; i < 6; i++) begin
      chk_head("t1", 32'(i));
      nxt();
    end

    // Asynchronous reset mid-stream
    reset = 1'b1;
    #1;
    chk("mr_v",  32'(inst_valid), 32'd0);
    chk("mr_i",  32'(inst), 32'd0);
    chk("mr_pc", inst_pc, 32'd0);
    nxt();

    // ready=0 after release: exactly four requests, head holds pc 0
    reset      = 1'b0;
    inst_ready = 1'b0;
    reqs       = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (imem_rd) begin
        chk("t2_addr", imem_addr, 32'(reqs));
        reqs++;
      end
      if (c >= 2) chk_head("t2_hold", 32'd0);
      nxt();
    end
    chk("t2_reqs", 32'(reqs), 32'd4);
    chk("t2_rd",   32'(imem_rd), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_head("t2_drain", 32'(i));
      nxt();
    end

    // Redirect with one request in flight and two queued
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    inst_ready     = 1'b0;
    nxt();
    redirect_valid = 1'b0;
    nxt();
    nxt();
    nxt();
    chk_head("t3_pre", 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b1;
    #1;
    chk("t3_redir_rd", 32'(imem_rd), 32'd0);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("t3_rd",   32'(imem_rd), 32'd1);
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_v0",   32'(inst_valid), 32'd0);
    nxt();
    chk("t3_v1", 32'(inst_valid), 32'd0);
    nxt();
    chk_head("t3_a", 32'h40);
    nxt();
    chk_head("t3_b", 32'h41);
    nxt();
    chk_head("t3_c", 32'h42);

    // Redirect to the top of the address space: PC wraps
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    nxt();
    redirect_valid = 1'b0;
    nxt();
    chk("t4_v1", 32'(inst_valid), 32'd0);
    nxt();
    chk_head("t4_a", 32'hFFFF_FFFF);
    nxt();
    chk_head("t4_b", 32'h0);
    nxt();
    chk_head("t4_c", 32'h1);

    // Nearly full FIFO plus in-flight return, then ready rises
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    inst_ready     = 1'b0;
    nxt();
    redirect_valid = 1'b0;
    for (int c = 0; c < 4; c++) nxt();
    #1;
    chk("t5_rd", 32'(imem_rd), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head("t5", 32'h100 + 32'(i));
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
